// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Byte-addressable data memory for the MEM stage. Sized loads/stores
//   (byte/half/word) with sign/zero extension, per-lane byte writes and a
//   registered one-cycle response. After reset a clear sequencer zeroes the
//   array one word per cycle before requests are accepted.
//
// Ports:
//   clk           clock, all state updates on posedge
//   reset         asynchronous, active-high reset
//   req_valid     request present
//   req_ready     memory can accept a request this cycle (state only)
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address, little-endian
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_error     access rejected; valid only with rsp_valid
//   busy          clear sequencer active (also high during reset)
module data_memory_sized #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] count, next_count;
    logic             clear_en;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             range_err, align_err, err;
    logic             accept, store_en;
    logic [3:0]       be;
    logic [31:0]      wrep;
    logic [31:0]      rword;
    logic [15:0]      shifted;
    logic [31:0]      load_data;

    // ---------------- clear sequencer FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        clear_en   = 1'b0;
        case (state)
            INIT: begin
                if (!CLEAR_ON_RESET) begin
                    next_state = READY;
                end else begin
                    clear_en   = 1'b1;
                    next_count = count + 1'b1;
                    if (count == '1) next_state = READY;
                end
            end
            READY: next_state = READY;
            default: next_state = INIT;
        endcase
    end

    assign req_ready = (state == READY);
    assign busy      = reset || (state == INIT);

    // ---------------- request decode ----------------
    assign idx  = req_addr[ADDR_WIDTH-1:2];
    assign lane = req_addr[1:0];

    // Any address bit above the decoded range makes the access out of range.
    assign range_err = (req_addr >> ADDR_WIDTH) != 32'd0;
    assign align_err = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign err       = range_err || align_err;

    assign accept   = req_valid && req_ready;
    assign store_en = accept && req_write && !err;

    always_comb begin
        be   = 4'b0000;
        wrep = req_wdata;
        case (req_size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be   = 4'b1111;
                wrep = req_wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    // ---------------- storage: one array per byte lane ----------------
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (clear_en)
                mem[count] <= '0;
            else if (store_en && be[l])
                mem[idx] <= wrep[8*l +: 8];
        end

        assign rword[8*l +: 8] = mem[idx];
    end

    // ---------------- load alignment and extension ----------------
    assign shifted = 16'(rword >> {lane, 3'b000});

    always_comb begin
        load_data = rword;
        case (req_size)
            2'b00: load_data = req_unsigned ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = req_unsigned ? {16'd0, shifted}
                                            : {{16{shifted[15]}}, shifted};
            default: load_data = rword;
        endcase
    end

    // ---------------- registered response ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_error <= accept && err;
            rsp_rdata <= (accept && !err && !req_write) ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized
//   Directed bench for data_memory_sized (ADDR_WIDTH=12). Expected responses
//   are queued when a request is accepted and compared on the following
//   negedge by a monitor; every other negedge expects rsp_valid low.
module tb_data_memory_sized;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    data_memory_sized #(
        .ADDR_WIDTH    (12),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor / scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            chk("rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        end else begin
            chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
        end
    end

    // Present a request from a negedge, expect acceptance at the next posedge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Reset has just been released at a negedge; count busy cycles.
    task automatic wait_clear(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1)
                chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        end while (busy === 1'b1 && n < 5000);
        chk({tag, "_cycles"}, n, 32'd1024);
        chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy",      {31'd0, busy},      32'd1);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata,          32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        reset = 1'b0;
        wait_clear("clear1");

        // Top word reads back cleared
        issue(1'b0, SZ_W, 1'b0, 32'h0FFC, 32'h0, 32'h0000_0000, 1'b0);

        // Word store then load next cycle
        issue(1'b1, SZ_W, 1'b0, 32'h0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte / half extension
        issue(1'b0, SZ_B, 1'b0, 32'h0101, 32'h0, 32'hFFFF_FFBE, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h0101, 32'h0, 32'h0000_00BE, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h0102, 32'h0, 32'hFFFF_DEAD, 1'b0);
        issue(1'b0, SZ_H, 1'b1, 32'h0102, 32'h0, 32'h0000_DEAD, 1'b0);
        issue(1'b0, SZ_B, 1'b0, 32'h0100, 32'h0, 32'hFFFF_FFEF, 1'b0);
        issue(1'b0, SZ_W, 1'b1, 32'h0100, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Partial stores keep untouched lanes
        issue(1'b1, SZ_B, 1'b0, 32'h0103, 32'hFFFF_FF12, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_BEEF, 1'b0);
        issue(1'b1, SZ_H, 1'b0, 32'h0100, 32'hFFFF_3456, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);

        // Errors: flagged, data 0, array untouched
        issue(1'b1, SZ_W, 1'b0, 32'h0102, 32'hAAAA_AAAA, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h0101, 32'h0, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);
        issue(1'b1, SZ_R, 1'b0, 32'h0100, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
        issue(1'b1, SZ_W, 1'b0, 32'h1100, 32'h5555_5555, 32'h0, 1'b1);
        issue(1'b1, SZ_B, 1'b0, 32'h8000_0100, 32'h0000_0077, 32'h0, 1'b1);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);

        // Dirty the top word, then reset with a load response in flight
        issue(1'b1, SZ_W, 1'b0, 32'h0FFC, 32'h55AA_55AA, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0FFC, 32'h0, 32'h55AA_55AA, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h12AD_3456, 1'b0);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("inflight_dropped", {31'd0, rsp_valid}, 32'd0);
        chk("inflight_busy",    {31'd0, busy},      32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset at INIT cycle 500, full clear reruns
        repeat (500) @(posedge clk);
        #1;
        chk("mid_init_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_init_busy_reset", {31'd0, busy},    32'd1);
        chk("mid_init_ready",      {31'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_clear("clear2");

        // Cleared again; back-to-back traffic
        issue(1'b0, SZ_W, 1'b0, 32'h0FFC, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0100, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h0000, 32'h1111_1111, 32'h0, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h0004, 32'h2222_2222, 32'h0, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h0008, 32'h8333_3333, 32'h0, 1'b0);
        issue(1'b1, SZ_W, 1'b0, 32'h000C, 32'h4444_4444, 32'h0, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0000, 32'h0, 32'h1111_1111, 1'b0);
        issue(1'b0, SZ_W, 1'b0, 32'h0004, 32'h0, 32'h2222_2222, 1'b0);
        issue(1'b0, SZ_H, 1'b0, 32'h000A, 32'h0, 32'hFFFF_8333, 1'b0);
        issue(1'b0, SZ_B, 1'b1, 32'h000F, 32'h0, 32'h0000_0044, 1'b0);
        idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
